maze_wall_arbiter: RTL and testbench
====================================

// Module: maze_wall_arbiter
// PURPOSE
//  Shares one single-port maze wall-map ROM between N movement requesters (pacman + ghost movers).
//  Each requester asks "is tile (row,col) a wall?" before committing a move; arbiter grants round-robin,
//  sequences ROM read + latency, returns wall bit with a one-cycle ack. Sits between movers and wall ROM.
// PARAMETERS
//  N_REQ    4   number of requesters (index 0 = pacman)
//  ROWS     33  maze tile rows (264 px / 8)
//  COLS     30  maze tile cols (240 px / 8)
//  ROW_W    6   tile row width
//  COL_W    5   tile col width
//  ADDR_W   10  ROM address width (ROWS*COLS <= 2**ADDR_W)
//  ROM_LAT  1   ROM read latency in clk edges (>=1)
// PORTS
//  clk       in   1              system clock; all logic on posedge
//  rst       in   1              reset, asynchronous, active-high
//  req       in   N_REQ          per-requester lookup request, level, held until ack
//  row       in   N_REQ*ROW_W    packed tile rows, slice i = requester i; stable while req[i]
//  col       in   N_REQ*COL_W    packed tile cols, same packing
//  ack       out  N_REQ          one-hot, one-cycle pulse: result for requester i valid
//  wall      out  1              lookup result (1 = wall), valid only while |ack
//  busy      out  1              high whenever state != IDLE
//  rom_en    out  1              ROM read enable
//  rom_addr  out  ADDR_W         ROM address = row*COLS + col
//  rom_data  in   1              ROM wall bit, valid ROM_LAT edges after rom_en sampled
// BEHAVIOUR
//  - Reset (async, immediate, also mid-transaction): state=IDLE, ack=0, wall=0, busy=0, rom_en=0,
//    rom_addr=0, rr_last=N_REQ-1 (requester 0 highest priority first). In-flight lookup dropped, no ack.
//  - All outputs registered. FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP for out-of-range.
//  - IDLE: if |req, grant first set req scanning from rr_last+1 modulo N_REQ; latch index, row, col;
//    rr_last <= granted index. Non-granted reqs wait, no side effects.
//  - Range check on latched coords: row>=ROWS or col>=COLS -> next RESP with wall=1, no ROM access.
//  - ISSUE: rom_en=1 for exactly one cycle, rom_addr=row*COLS+col (ADDR_W-bit, no truncation in range).
//  - WAIT: counter counts ROM_LAT edges; on last, capture rom_data into wall.
//  - RESP: ack[idx]=1 for exactly one cycle, wall held; then IDLE. rom_addr holds last value (rom_en=0).
//  - Latency: req sampled in IDLE at edge E0 -> ack high in cycle after edge E0+2+ROM_LAT (in range),
//    after E0+1 (out of range). Throughput: one lookup per 3+ROM_LAT cycles.
//  - Handshake: requester drops req on the edge it samples ack=1; req still high in next IDLE = new lookup.
//    Dropping req before ack is illegal; the lookup still completes and acks.
//  - Fairness: with all reqs held, grants rotate 0,1,2,3,0...; a lone requester is granted back-to-back.
//  - Simultaneous: req rising during busy is sampled only in next IDLE; never more than one ack bit set.
// STRUCTURE
//  - Shared package maze_pkg: MAZE_ROWS, MAZE_COLS, TILE_PX=8, MAZE_X0=200, MAZE_Y0=100, ROW_W, COL_W,
//    ADDR_W, FSM state encoding (IDLE/ISSUE/WAIT/RESP).
//  - One sub-module rr_arbiter (N_REQ, req, rr_last -> one-hot grant + index), combinational.
//  - FSM, latency counter, address multiply (constant COLS) in top.
// TESTING (bench models wall ROM with ROM_LAT-cycle registered read)
//  1 Reset: rst pulse mid-WAIT -> ack=0, busy=0, rom_en=0 immediately; no ack ever for dropped lookup.
//  2 Single lookup req[0], row=1,col=2, ROM[32]=1 -> rom_en one cycle with rom_addr=32; ack=0001,
//    wall=1 in cycle after E0+3 (ROM_LAT=1).
//  3 Out of range req[2], row=40 -> ack=0100, wall=1 after E0+1; rom_en never asserted.
//  4 All four req held continuously, auto-drop on ack -> ack order 0001,0010,0100,1000,0001; never >1 bit.
//  5 req[1] only, re-raised after each ack -> granted back-to-back, every 4 cycles (ROM_LAT=1).
//  6 ROM_LAT=3 build, row=32,col=29 -> rom_addr=989, ack after E0+5, wall equals ROM[989].

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze geometry and arbiter FSM encoding.
// Imported by the wall-map arbiter and its round-robin picker.
package maze_pkg;

    localparam int MAZE_ROWS = 33;
    localparam int MAZE_COLS = 30;
    localparam int TILE_PX   = 8;
    localparam int MAZE_X0   = 200;
    localparam int MAZE_Y0   = 100;
    localparam int ROW_W     = 6;
    localparam int COL_W     = 5;
    localparam int ADDR_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/maze_wall_arbiter_if.sv
// Requester + wall-ROM bundle around the maze wall arbiter.
// master = movers and ROM side, slave = arbiter.
interface maze_wall_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 5,
    parameter int ADDR_W = 10
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*ROW_W-1:0] row;
    logic [N_REQ*COL_W-1:0] col;
    logic [N_REQ-1:0]       ack;
    logic                   wall;
    logic                   busy;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic                   rom_data;

    modport master (
        output req, row, col, rom_data,
        input  ack, wall, busy, rom_en, rom_addr
    );

    modport slave (
        input  req, row, col, rom_data,
        output ack, wall, busy, rom_en, rom_addr
    );

endinterface

// File: rtl/maze_wall_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request
// scanning upward from the one after the last grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_rr_last,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin : pick
        int k;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        k       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(i_rr_last) + i) % N_REQ;
            if (!o_valid && i_req[k]) begin
                o_valid    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/maze_wall_arbiter.sv
// Shares one single-port wall ROM between maze movers:
// round-robin grant, ROM sequencing, one-cycle ack.
module maze_wall_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ROWS    = maze_pkg::MAZE_ROWS,
    parameter int COLS    = maze_pkg::MAZE_COLS,
    parameter int ROW_W   = maze_pkg::ROW_W,
    parameter int COL_W   = maze_pkg::COL_W,
    parameter int ADDR_W  = maze_pkg::ADDR_W,
    parameter int ROM_LAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    maze_wall_arbiter_if.slave  io_bus
);

    import maze_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT_W = $clog2(ROM_LAT + 1);
    localparam logic [LAT_W-1:0] CNT_LAST = LAT_W'(ROM_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    r_rr_last;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [LAT_W-1:0]    r_cnt;
    logic [LAT_W-1:0]    w_cnt_nxt;
    logic                r_wall;
    logic                w_wall_nxt;
    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    w_ack_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_rom_en;
    logic                w_rom_en_nxt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;

    logic [N_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_vld;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;
    logic                w_oor;
    logic [ADDR_W-1:0]   w_addr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req     (io_bus.req),
        .i_rr_last (r_rr_last),
        .o_grant   (w_gnt),
        .o_idx     (w_gnt_idx),
        .o_valid   (w_gnt_vld)
    );

    // Coordinates of the winner; decoded on the grant edge
    assign w_row  = io_bus.row[w_gnt_idx*ROW_W +: ROW_W];
    assign w_col  = io_bus.col[w_gnt_idx*COL_W +: COL_W];
    assign w_oor  = (int'(w_row) >= ROWS) ||
                    (int'(w_col) >= COLS);
    assign w_addr = ADDR_W'(w_row) * ADDR_W'(COLS)
                  + ADDR_W'(w_col);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_rr_nxt     = r_rr_last;
        w_cnt_nxt    = r_cnt;
        w_wall_nxt   = r_wall;
        w_ack_nxt    = '0;
        w_rom_en_nxt = 1'b0;
        w_addr_nxt   = r_rom_addr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_idx_nxt = w_gnt_idx;
                    w_rr_nxt  = w_gnt_idx;
                    if (w_oor) begin
                        w_state_nxt = ST_RESP;
                        w_wall_nxt  = 1'b1;
                        w_ack_nxt   = w_gnt;
                    end else begin
                        w_state_nxt  = ST_ISSUE;
                        w_rom_en_nxt = 1'b1;
                        w_addr_nxt   = w_addr;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end
            ST_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt      = ST_RESP;
                    w_wall_nxt       = io_bus.rom_data;
                    w_ack_nxt[r_idx] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_rr_last  <= IDX_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_wall     <= 1'b0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rr_last  <= w_rr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wall     <= w_wall_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_rom_en   <= w_rom_en_nxt;
            r_rom_addr <= w_addr_nxt;
        end
    end

    assign io_bus.ack      = r_ack;
    assign io_bus.wall     = r_wall;
    assign io_bus.busy     = r_busy;
    assign io_bus.rom_en   = r_rom_en;
    assign io_bus.rom_addr = r_rom_addr;

endmodule

// File: tb/tb_maze_wall_arbiter.sv
// Directed bench for maze_wall_arbiter: ROM_LAT=1 and
// ROM_LAT=3 instances, each fed by a registered ROM model.
module tb_maze_wall_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    maze_wall_arbiter_if #(.N_REQ(4)) bus ();
    maze_wall_arbiter_if #(.N_REQ(4)) bus3 ();

    maze_wall_arbiter #(.ROM_LAT(1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    maze_wall_arbiter #(.ROM_LAT(3)) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus3)
    );

    function automatic logic rom_fn(input logic [9:0] a);
        return a[0] ^ a[3] ^ a[5] ^ a[9];
    endfunction

    // Outside the valid window the ROM output flips, so a
    // capture on the wrong edge returns the wrong bit.
    logic       p1;
    logic [2:0] p3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= 1'b0;
            p3 <= '0;
        end else begin
            p1 <= bus.rom_en ? rom_fn(bus.rom_addr) : ~p1;
            p3 <= {p3[1:0], bus3.rom_en ?
                   rom_fn(bus3.rom_addr) : ~p3[0]};
        end
    end
    assign bus.rom_data  = p1;
    assign bus3.rom_data = p3[2];

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic run_lookup(
        input  int         sel,
        input  int         rq,
        input  logic [5:0] r,
        input  logic [4:0] c,
        output int         lat,
        output logic [3:0] ackv,
        output logic       wv,
        output int         en_n,
        output logic [9:0] addr,
        output int         multi
    );
        logic [3:0] a;
        logic       en;
        logic [9:0] ad;
        logic       w;
        lat   = 99;
        ackv  = '0;
        wv    = 1'b0;
        en_n  = 0;
        addr  = '0;
        multi = 0;
        if (sel == 0) begin
            bus.row[rq*6 +: 6] = r;
            bus.col[rq*5 +: 5] = c;
            bus.req[rq]        = 1'b1;
        end else begin
            bus3.row[rq*6 +: 6] = r;
            bus3.col[rq*5 +: 5] = c;
            bus3.req[rq]        = 1'b1;
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            a  = (sel == 0) ? bus.ack : bus3.ack;
            en = (sel == 0) ? bus.rom_en : bus3.rom_en;
            ad = (sel == 0) ? bus.rom_addr : bus3.rom_addr;
            w  = (sel == 0) ? bus.wall : bus3.wall;
            if (en) begin
                en_n++;
                addr = ad;
            end
            if ($countones(a) > 1) multi++;
            if (a != 0) begin
                lat  = n;
                ackv = a;
                wv   = w;
                break;
            end
        end
        tick();
        bus.req  = '0;
        bus3.req = '0;
    endtask

    typedef struct {
        int         sel;
        int         rq;
        logic [5:0] row;
        logic [4:0] col;
        logic [3:0] ack;
        logic       wall;
        int         lat;
        int         rom;
        logic [9:0] addr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int         lat;
        logic [3:0] ackv;
        logic       wv;
        int         en_n;
        logic [9:0] addr;
        int         multi;
        int         nack;
        int         last_c;
        logic [3:0] ack_prev;
        logic [3:0] drop_prev;
        logic       seen;

        vecs[0]  = '{0, 0,  1,  2, 4'b0001, 1'b1, 3, 1, 10'd32};
        vecs[1]  = '{0, 2, 40,  0, 4'b0100, 1'b1, 1, 0, 10'd0};
        vecs[2]  = '{0, 1,  0, 30, 4'b0010, 1'b1, 1, 0, 10'd0};
        vecs[3]  = '{0, 3, 32, 29, 4'b1000, 1'b1, 3, 1, 10'd989};
        vecs[4]  = '{0, 3,  1,  3, 4'b1000, 1'b0, 3, 1, 10'd33};
        vecs[5]  = '{0, 0,  0,  0, 4'b0001, 1'b0, 3, 1, 10'd0};
        vecs[6]  = '{0, 1, 33, 29, 4'b0010, 1'b1, 1, 0, 10'd0};
        vecs[7]  = '{0, 2, 32,  0, 4'b0100, 1'b1, 3, 1, 10'd960};
        vecs[8]  = '{1, 0, 32, 29, 4'b0001, 1'b1, 5, 1, 10'd989};
        vecs[9]  = '{1, 3, 50,  3, 4'b1000, 1'b1, 1, 0, 10'd0};
        vecs[10] = '{1, 2,  1,  3, 4'b0100, 1'b0, 5, 1, 10'd33};

        bus.req  = '0;
        bus.row  = '0;
        bus.col  = '0;
        bus3.req = '0;
        bus3.row = '0;
        bus3.col = '0;
        tick();
        tick();
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_wall", int'(bus.wall), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rom_en", int'(bus.rom_en), 0);
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        rst = 1'b0;
        tick();

        // Reset pulse while the lookup sits in WAIT
        bus.row[5:0] = 6'd1;
        bus.col[4:0] = 5'd2;
        bus.req[0]   = 1'b1;
        tick();
        tick();
        chk("midwait_busy_pre", int'(bus.busy), 1);
        chk("midwait_addr_pre", int'(bus.rom_addr), 32);
        rst     = 1'b1;
        bus.req = '0;
        #1;
        chk("midwait_ack", int'(bus.ack), 0);
        chk("midwait_busy", int'(bus.busy), 0);
        chk("midwait_rom_en", int'(bus.rom_en), 0);
        chk("midwait_addr", int'(bus.rom_addr), 0);
        tick();
        rst  = 1'b0;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ack != 0) nack++;
        end
        chk("midwait_no_ack", nack, 0);

        // All four requesters, drop on ack, re-raise next edge
        for (int i = 0; i < 4; i++) begin
            bus.row[i*6 +: 6] = 6'(i + 2);
            bus.col[i*5 +: 5] = 5'(i + 1);
        end
        bus.req   = 4'b1111;
        ack_prev  = '0;
        drop_prev = '0;
        nack      = 0;
        last_c    = 0;
        for (int c = 0; c < 60 && nack < 5; c++) begin
            tick();
            bus.req   = (bus.req | drop_prev) & ~ack_prev;
            drop_prev = ack_prev;
            ack_prev  = bus.ack;
            if ($countones(bus.ack) > 1)
                chk("rot_onehot", $countones(bus.ack), 1);
            if (bus.ack != 0) begin
                chk($sformatf("rot_ack%0d", nack),
                    int'(bus.ack), 1 << (nack % 4));
                if (nack > 0)
                    chk($sformatf("rot_gap%0d", nack),
                        c - last_c, 4);
                last_c = c;
                nack++;
            end
        end
        chk("rot_count", nack, 5);
        tick();
        bus.req = '0;
        tick();
        tick();

        foreach (vecs[i]) begin
            run_lookup(vecs[i].sel, vecs[i].rq, vecs[i].row,
                       vecs[i].col, lat, ackv, wv, en_n, addr,
                       multi);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_ack", i), int'(ackv),
                int'(vecs[i].ack));
            chk($sformatf("v%0d_wall", i), int'(wv),
                int'(vecs[i].wall));
            chk($sformatf("v%0d_rom_en", i), en_n,
                vecs[i].rom);
            if (vecs[i].rom != 0)
                chk($sformatf("v%0d_addr", i), int'(addr),
                    int'(vecs[i].addr));
            chk($sformatf("v%0d_multi", i), multi, 0);
        end

        // Lone requester 1, dropped and re-raised on each ack
        bus.row[11:6] = 6'd1;
        bus.col[9:5]  = 5'd2;
        bus.req       = 4'b0010;
        seen   = 1'b0;
        nack   = 0;
        last_c = 0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            tick();
            if (seen) begin
                bus.req[1] = 1'b0;
                #1;
                bus.req[1] = 1'b1;
            end
            seen = (bus.ack != 0);
            if (seen) begin
                chk($sformatf("lone_ack%0d", nack),
                    int'(bus.ack), 2);
                chk($sformatf("lone_wall%0d", nack),
                    int'(bus.wall), 1);
                if (nack > 0)
                    chk($sformatf("lone_gap%0d", nack),
                        c - last_c, 4);
                last_c = c;
                nack++;
            end
        end
        chk("lone_count", nack, 4);
        tick();
        bus.req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
